deck_shuffle_ctrl: RTL

- Sequencer that owns the 52-entry card RAM and drives the Nxt_Addr shuffle datapath.
- On reset it loads the identity deck (card k at address k).
- On request it walks Addr_i 0..51 and swaps RAM[i] with RAM[Addr_j]; Addr_j comes from Nxt_Addr, fed by the free-running Counter.
- It then deals cards sequentially to the game FSM with a draw/valid handshake.

---
 rtl/deck_pkg.sv | 26 ++
 rtl/card_ram.sv | 28 ++
 rtl/deck_shuffle_ctrl.sv | 135 +++++++++++++
 3 files changed

// File: rtl/deck_pkg.sv
// deck_pkg: shared sizes and the sequencer state encoding for the card deck shuffler.
`default_nettype none

package deck_pkg;

  localparam int DECK_SIZE   = 52;
  localparam int ADDR_W      = 6;
  localparam int CARD_W      = 6;
  localparam int SWAP_CYCLES = 5;

  typedef enum logic [3:0] {
    INIT   = 4'd0,
    IDLE   = 4'd1,
    RD_I   = 4'd2,
    RD_J   = 4'd3,
    CAP_J  = 4'd4,
    WR_I   = 4'd5,
    WR_J   = 4'd6,
    DONE   = 4'd7,
    DR_RD  = 4'd8,
    DR_CAP = 4'd9
  } state_t;

endpackage

`default_nettype wire

// File: rtl/card_ram.sv
// card_ram: DECK_SIZE x CARD_W single-port RAM with registered read (read-before-write).
`default_nettype none

module card_ram
  import deck_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we,
  input  logic [CARD_W-1:0] wdata,
  output logic [CARD_W-1:0] rdata
);

  logic [CARD_W-1:0] mem [DECK_SIZE];
  logic              in_range;

  assign in_range = (addr < ADDR_W'(DECK_SIZE));

  always_ff @(posedge clk) begin
    if (we && in_range) begin
      mem[addr] <= wdata;
    end
    rdata <= in_range ? mem[addr] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/deck_shuffle_ctrl.sv
// deck_shuffle_ctrl: builds the identity deck, runs the Addr_i/Addr_j swap shuffle
// over the external card RAM, then deals cards one at a time on request.
`default_nettype none

module deck_shuffle_ctrl
  import deck_pkg::*;
(
  input  logic              clk_2K,
  input  logic              i_Reset,
  input  logic              i_Shuffle,
  input  logic              i_Draw,
  output logic [ADDR_W-1:0] o_Addr_i,
  input  logic [ADDR_W-1:0] i_Addr_j,
  output logic [ADDR_W-1:0] o_RamAddr,
  output logic              o_RamWe,
  output logic [CARD_W-1:0] o_RamWData,
  input  logic [CARD_W-1:0] i_RamRData,
  output logic [CARD_W-1:0] o_Card,
  output logic              o_CardValid,
  output logic              o_Busy,
  output logic              o_Done,
  output logic              o_Empty
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DECK_SIZE - 1);
  localparam logic [ADDR_W-1:0] SIZE = ADDR_W'(DECK_SIZE);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] init_k, idx_i, ptr, jl;
  logic [CARD_W-1:0] ti, tj;
  logic              we_raw;

  always_ff @(posedge clk_2K or negedge i_Reset) begin
    if (!i_Reset) state <= INIT;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT:    if (init_k == LAST) state_nxt = IDLE;
      IDLE: begin
        if (i_Shuffle)              state_nxt = RD_I;
        else if (i_Draw && !o_Empty) state_nxt = DR_RD;
      end
      RD_I:    state_nxt = RD_J;
      RD_J:    state_nxt = CAP_J;
      CAP_J:   state_nxt = WR_I;
      WR_I:    state_nxt = WR_J;
      WR_J:    state_nxt = (idx_i == LAST) ? DONE : RD_I;
      DONE:    state_nxt = IDLE;
      DR_RD:   state_nxt = DR_CAP;
      DR_CAP:  state_nxt = IDLE;
      default: state_nxt = INIT;
    endcase
  end

  always_comb begin
    o_RamAddr  = '0;
    o_RamWData = '0;
    we_raw     = 1'b0;
    case (state)
      INIT: begin
        o_RamAddr  = init_k;
        o_RamWData = CARD_W'(init_k);
        we_raw     = 1'b1;
      end
      RD_I:  o_RamAddr = idx_i;
      RD_J:  o_RamAddr = jl;
      WR_I: begin
        o_RamAddr  = idx_i;
        o_RamWData = tj;
        we_raw     = 1'b1;
      end
      WR_J: begin
        o_RamAddr  = jl;
        o_RamWData = ti;
        we_raw     = 1'b1;
      end
      DR_RD: o_RamAddr = ptr;
      default: ;
    endcase
  end

  // INIT is the reset state, so the write strobe must be masked while reset is held.
  assign o_RamWe  = we_raw & i_Reset;
  assign o_Busy   = (state != IDLE);
  assign o_Done   = (state == DONE);
  assign o_Addr_i = idx_i;

  always_ff @(posedge clk_2K or negedge i_Reset) begin
    if (!i_Reset) begin
      init_k      <= '0;
      idx_i       <= '0;
      ptr         <= '0;
      jl          <= '0;
      ti          <= '0;
      tj          <= '0;
      o_Card      <= '0;
      o_CardValid <= 1'b0;
      o_Empty     <= 1'b1;
    end else begin
      o_CardValid <= 1'b0;
      case (state)
        INIT: init_k <= init_k + 1'b1;
        IDLE: begin
          if (i_Shuffle) begin
            idx_i   <= '0;
            ptr     <= '0;
            o_Empty <= 1'b1;
          end
        end
        // Partner indices past the deck fold back into range instead of being rejected.
        RD_I:  jl <= (i_Addr_j >= SIZE) ? (i_Addr_j - SIZE) : i_Addr_j;
        RD_J:  ti <= i_RamRData;
        CAP_J: tj <= i_RamRData;
        WR_J:  if (idx_i != LAST) idx_i <= idx_i + 1'b1;
        DONE: begin
          o_Empty <= 1'b0;
          idx_i   <= '0;
        end
        DR_CAP: begin
          o_Card      <= i_RamRData;
          o_CardValid <= 1'b1;
          ptr         <= ptr + 1'b1;
          if (ptr == LAST) o_Empty <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
